// File: rtl/serial_addsub_if.sv
// Handshake bundle for serial_addsub: operand side (in_*, a, b, sub_mode)
// and result side (out_*, result, flags, busy).
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, sub_mode, out_ready,
    input  in_ready, out_valid, result, flag, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub_mode, out_ready,
    output in_ready, out_valid, result, flag, overflow, busy
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract: one DIGIT-bit ripple slice reused for
// WIDTH/DIGIT cycles, LSB digit first, with carry/borrow and signed overflow.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst,
  serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    digBase;
  logic [DIGIT-1:0] aDig, bDig, sumDig;
  logic             carryOut;
  logic             ovfDig;
  logic             lastDig;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (lastDig)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.result    = result_q;
    bus.flag      = flag_q;
    bus.overflow  = ovf_q;
  end

  // b is stored pre-inverted for subtraction; the +1 comes from the carry preset.
  always_comb begin
    digBase  = IW'(int'(cnt_q) * DIGIT);
    lastDig  = (cnt_q == CW'(NDIG - 1));
    aDig     = a_q[digBase +: DIGIT];
    bDig     = b_q[digBase +: DIGIT];
    {carryOut, sumDig} = {1'b0, aDig} + {1'b0, bDig} + {{DIGIT{1'b0}}, carry_q};
    ovfDig   = ~(aDig[DIGIT-1] ^ bDig[DIGIT-1]) & (sumDig[DIGIT-1] ^ aDig[DIGIT-1]);

    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_d   = flag_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub_mode ? ~bus.b : bus.b;
          sub_d   = bus.sub_mode;
          carry_d = bus.sub_mode;
          cnt_d   = '0;
        end
      end
      RUN: begin
        result_d[digBase +: DIGIT] = sumDig;
        carry_d = carryOut;
        cnt_d   = cnt_q + 1'b1;
        if (lastDig) begin
          flag_d = carryOut ^ sub_q;
          ovf_d  = ovfDig;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a 16/4 instance for the main vectors and
// an 8/8 instance for the single-cycle configuration.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(16)) bus16 ();
  serial_addsub_if #(.WIDTH(8))  bus8 ();

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand set for a single accept edge.
  task automatic applyStimulus(input bit use8, input logic [15:0] av, input logic [15:0] bv, input logic s);
    int waitCycles = 0;
    while (((use8 ? bus8.in_ready : bus16.in_ready) !== 1'b1) && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    compare("in_ready_before_issue", {31'd0, use8 ? bus8.in_ready : bus16.in_ready}, 32'd1);
    if (use8) begin
      bus8.a = av[7:0];
      bus8.b = bv[7:0];
      bus8.sub_mode = s;
      bus8.in_valid = 1'b1;
    end else begin
      bus16.a = av;
      bus16.b = bv;
      bus16.sub_mode = s;
      bus16.in_valid = 1'b1;
    end
    tick();
    bus8.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
  endtask

  // Measures latency from the accept edge, checks results, then consumes them.
  task automatic checkOutput(input string tag, input bit use8, input int expLat,
                             input logic [15:0] expRes, input logic expFlag, input logic expOvf);
    int lat = 0;
    while (((use8 ? bus8.out_valid : bus16.out_valid) !== 1'b1) && lat < 40) begin
      tick();
      lat++;
    end
    compare({tag, "_latency"}, lat, expLat);
    compare({tag, "_result"}, use8 ? {24'd0, bus8.result} : {16'd0, bus16.result}, {16'd0, expRes});
    compare({tag, "_flag"}, {31'd0, use8 ? bus8.flag : bus16.flag}, {31'd0, expFlag});
    compare({tag, "_overflow"}, {31'd0, use8 ? bus8.overflow : bus16.overflow}, {31'd0, expOvf});
    compare({tag, "_in_ready_done"}, {31'd0, use8 ? bus8.in_ready : bus16.in_ready}, 32'd0);
    if (use8) bus8.out_ready = 1'b1;
    else      bus16.out_ready = 1'b1;
    tick();
    bus8.out_ready  = 1'b0;
    bus16.out_ready = 1'b0;
    compare({tag, "_out_valid_after"}, {31'd0, use8 ? bus8.out_valid : bus16.out_valid}, 32'd0);
    compare({tag, "_in_ready_after"}, {31'd0, use8 ? bus8.in_ready : bus16.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int  waitCycles;
    bit  sawValid;

    // Reset with in_valid asserted: must not be accepted.
    rst = 1'b1;
    bus16.in_valid = 1'b1; bus16.a = 16'd9; bus16.b = 16'd4; bus16.sub_mode = 1'b1;
    bus16.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.sub_mode = 1'b0;
    bus8.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    bus16.in_valid = 1'b0;
    compare("reset_in_ready", {31'd0, bus16.in_ready}, 32'd1);
    compare("reset_out_valid", {31'd0, bus16.out_valid}, 32'd0);
    compare("reset_busy", {31'd0, bus16.busy}, 32'd0);
    compare("reset_result", {16'd0, bus16.result}, 32'd0);
    compare("reset_flag", {31'd0, bus16.flag}, 32'd0);
    compare("reset_overflow", {31'd0, bus16.overflow}, 32'd0);
    compare("reset_d8_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    tick();
    compare("reset_valid_not_accepted", {31'd0, bus16.busy}, 32'd0);

    // Subtract / add corner vectors.
    applyStimulus(0, 16'd9, 16'd4, 1'b1);
    checkOutput("sub_9_4", 0, 4, 16'h0005, 1'b0, 1'b0);
    applyStimulus(0, 16'd3, 16'd7, 1'b1);
    checkOutput("sub_3_7", 0, 4, 16'hFFFC, 1'b1, 1'b0);
    applyStimulus(0, 16'd0, 16'd1, 1'b1);
    checkOutput("sub_0_1", 0, 4, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0);
    checkOutput("add_ffff_1", 0, 4, 16'h0000, 1'b1, 1'b0);
    applyStimulus(0, 16'h7FFF, 16'h0001, 1'b0);
    checkOutput("add_7fff_1", 0, 4, 16'h8000, 1'b0, 1'b1);
    applyStimulus(0, 16'h8000, 16'h0001, 1'b1);
    checkOutput("sub_8000_1", 0, 4, 16'h7FFF, 1'b0, 1'b1);
    applyStimulus(0, 16'd5, 16'd5, 1'b1);
    checkOutput("sub_5_5", 0, 4, 16'h0000, 1'b0, 1'b0);

    // Back-pressure: hold DONE for 10 cycles with a competing in_valid.
    applyStimulus(0, 16'h1234, 16'h1111, 1'b0);
    waitCycles = 0;
    while (bus16.out_valid !== 1'b1 && waitCycles < 40) begin
      tick();
      waitCycles++;
    end
    compare("stall_latency", waitCycles, 32'd4);
    bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.sub_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      compare("stall_result", {16'd0, bus16.result}, 32'h2345);
      compare("stall_out_valid", {31'd0, bus16.out_valid}, 32'd1);
      compare("stall_in_ready", {31'd0, bus16.in_ready}, 32'd0);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    compare("stall_release_out_valid", {31'd0, bus16.out_valid}, 32'd0);
    compare("stall_release_in_ready", {31'd0, bus16.in_ready}, 32'd1);
    tick();
    compare("stall_single_handshake_busy", {31'd0, bus16.busy}, 32'd0);
    compare("stall_single_handshake_valid", {31'd0, bus16.out_valid}, 32'd0);

    // Reset during the second RUN cycle discards the operation.
    applyStimulus(0, 16'h1234, 16'h0FFF, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compare("midrst_busy", {31'd0, bus16.busy}, 32'd0);
    compare("midrst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
    compare("midrst_in_ready", {31'd0, bus16.in_ready}, 32'd1);
    compare("midrst_result", {16'd0, bus16.result}, 32'd0);
    compare("midrst_flag", {31'd0, bus16.flag}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus16.out_valid !== 1'b0) sawValid = 1'b1;
    end
    compare("midrst_no_stale_valid", {31'd0, sawValid}, 32'd0);
    applyStimulus(0, 16'h1234, 16'h0FFF, 1'b1);
    checkOutput("sub_1234_0fff", 0, 4, 16'h0235, 1'b0, 1'b0);

    // Single-digit configuration: one-cycle latency.
    applyStimulus(1, 16'd9, 16'd4, 1'b1);
    checkOutput("d8_sub_9_4", 1, 1, 16'h0005, 1'b0, 1'b0);
    applyStimulus(1, 16'd3, 16'd7, 1'b1);
    checkOutput("d8_sub_3_7", 1, 1, 16'h00FC, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised, digit-serial add/subtract unit generalising the team's 4-bit subtractor to WIDTH-bit operands. It has a selectable add or subtract mode, and reports both a carry/borrow flag and a signed-overflow flag. Operands are accepted through a valid/ready handshake and processed DIGIT bits per clock, least-significant digit first, through a single DIGIT-bit ripple slice. The result is held under a second valid/ready handshake. It is the area-lean arithmetic block for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; WIDTH must be an integer multiple of DIGIT.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend / augend, unsigned or two's complement.
- b  input  WIDTH  subtrahend / addend.
- sub_mode  input  1  1 = a − b, 0 = a + b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  a ± b modulo 2^WIDTH.
- flag  output  1  subtract: borrow (1 when a < b unsigned); add: carry-out.
- overflow  output  1  signed two's-complement overflow of the operation.
- busy  output  1  state is not IDLE.

## Operation
- Let NDIG = WIDTH/DIGIT.
- States:
  - IDLE: in_ready=1.
  - RUN: NDIG digit cycles.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→RUN on in_valid&&in_ready. Capture a, b, sub_mode. Clear the digit counter. Preset the carry register to sub_mode.
  - RUN: each cycle, process digit k of a with digit k of b. b is inverted when sub_mode=1.
    - Compute carry-in + a_k + b'_k over DIGIT bits.
    - Write the sum into result bits [k*DIGIT +: DIGIT].
    - Update the carry register and increment k.
  - RUN→DONE after digit NDIG−1 is written.
  - DONE→IDLE on out_ready.
- Subtraction is a + ~b + 1. Final carry c:
  - flag = ~c when sub_mode=1.
  - flag = c when sub_mode=0.
- overflow = carry into MSB XOR carry out of MSB, captured in the last RUN cycle.
- result, flag and overflow are stable and unchanged throughout DONE. The previous result is retained in IDLE. Only out_valid qualifies it.
- in_valid and operand changes during RUN/DONE are ignored. No second transaction is accepted until DONE→IDLE.
- rst in any state:
  - Next state IDLE, counter 0.
  - result 0, flag 0, overflow 0, out_valid 0, busy 0, in_ready 1.
  - An in-flight operation is discarded and never produces out_valid.
- in_valid asserted during the reset cycle is not accepted.

## Timing
- Accept edge E0: the rising edge where in_valid&&in_ready.
- Digits are processed on edges E1…E_NDIG.
- out_valid rises after edge E_NDIG. Latency from accept to out_valid is NDIG cycles; the default is 4.
- If out_ready=1 while out_valid=1, the result is consumed on that edge. in_ready returns 1 the following cycle.
- Minimum issue interval: NDIG + 2 cycles with out_ready held high.
- out_ready held low keeps DONE indefinitely, with outputs frozen.
- in_ready and out_valid are never high simultaneously.
- busy = (state != IDLE). All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Reset, then apply 9 − 4 (sub_mode=1) -> after 4 cycles: out_valid=1, result=5, flag=0, overflow=0.
- Apply 3 − 7 -> result=0xFFFC, flag=1, overflow=0. Then apply 0 − 1 -> result=0xFFFF, flag=1.
- Apply 0xFFFF + 0x0001 (sub_mode=0) -> result=0x0000, flag=1, overflow=0. Then apply 0x7FFF + 1 -> result=0x8000, flag=0, overflow=1.
- Apply 0x8000 − 1 -> result=0x7FFF, flag=0, overflow=1. Then apply 5 − 5 -> result=0, flag=0, overflow=0.
- Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored. Release -> exactly one handshake, then in_ready=1 the next cycle.
- Assert rst on the 2nd RUN cycle of 0x1234 − 0x0FFF -> next cycle: IDLE, out_valid=0, result=0, in_ready=1. No stale out_valid follows. Then apply 0x1234 − 0x0FFF -> result=0x0235, flag=0.
- Use WIDTH=8, DIGIT=8 -> 1-cycle latency. Re-run the 9 − 4 and 3 − 7 vectors -> 5 and 0xFC with borrow=1.
